// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants,
// common to the receive path and the future transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_START  = 7;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a configurable
// reset value so an idle-high line does not look like activity out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first frame recovery with stop-bit check.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err port.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic            parity_err
`endif
);

    localparam int S_W = (SB_TICK > 16) ? 5 : 4;
    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    uart_state_t     state;
    logic [S_W-1:0]  s_cnt;
    logic [N_W-1:0]  n_cnt;
    logic [DBIT-1:0] b;
    logic            rx_s;
`ifdef UART_RX_PARITY_EN
    logic            par_bit;
`endif

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            s_cnt        <= '0;
            n_cnt        <= '0;
            b            <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit      <= 1'b0;
            parity_err   <= 1'b0;
`endif
        end else begin
            rx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s_cnt <= '0;
                    end
                end
                // A start bit that is no longer low at its midpoint is treated as a glitch.
                START: begin
                    if (s_tick) begin
                        if (s_cnt == S_W'(MID_START)) begin
                            if (!rx_s) begin
                                state <= DATA;
                                s_cnt <= '0;
                                n_cnt <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s_cnt <= s_cnt + S_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_cnt == S_W'(OVERSAMPLE - 1)) begin
                            s_cnt <= '0;
                            b     <= {rx_s, b[DBIT-1:1]};
                            if (n_cnt == N_W'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                n_cnt <= n_cnt + N_W'(1);
                            end
                        end else begin
                            s_cnt <= s_cnt + S_W'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (s_tick) begin
                        if (s_cnt == S_W'(OVERSAMPLE - 1)) begin
                            par_bit <= rx_s;
                            s_cnt   <= '0;
                            state   <= STOP;
                        end else begin
                            s_cnt <= s_cnt + S_W'(1);
                        end
                    end
                end
`endif
                // The word is delivered even when the stop bit is bad; frame_err flags it.
                STOP: begin
                    if (s_tick) begin
                        if (s_cnt == S_W'(SB_TICK - 1)) begin
                            dout         <= b;
                            frame_err    <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                            parity_err   <= (^b) ^ par_bit;
`endif
                            rx_done_tick <= 1'b1;
                            s_cnt        <= '0;
                            state        <= IDLE;
                        end else begin
                            s_cnt <= s_cnt + S_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are pushed as expectations when sent,
// a monitor pops and compares on every rx_done_tick. Honours UART_RX_PARITY_EN.
module tb_uart_rx;

    localparam int DIV = 5;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME_TICKS = 16 * (10 + PBITS);

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       rx     = 1'b1;
    logic       s_tick = 1'b0;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    exp_t sb_q[$];
    int   strobe_ticks[$];
    int   errors     = 0;
    int   checks     = 0;
    int   tick_count = 0;
    int   tick_phase = 0;
    logic prev_done  = 1'b0;
    exp_t mon_e;
    int   n0;

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    initial forever #5 clk = ~clk;

    // One-cycle s_tick every DIV clocks, driven away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (tick_phase == DIV - 1) begin
                tick_phase = 0;
                s_tick     = 1'b1;
                tick_count++;
            end else begin
                tick_phase++;
                s_tick = 1'b0;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (!s_tick);
        end
    endtask

    task automatic put_bit(input logic v, input int n);
        @(negedge clk);
        rx = v;
        wait_ticks(n);
    endtask

    // Sends one frame; stop_ok=0 holds the stop bit low across its midpoint.
    task automatic apply_stimulus(input logic [7:0] data, input bit stop_ok, input bit par_ok);
        exp_t e;
        e.data = data;
        e.ferr = !stop_ok;
        e.perr = !par_ok;
        sb_q.push_back(e);
        put_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) put_bit(data[i], 16);
`ifdef UART_RX_PARITY_EN
        put_bit(par_ok ? (^data) : ~(^data), 16);
`endif
        if (stop_ok) begin
            put_bit(1'b1, 16);
        end else begin
            put_bit(1'b0, 12);
            put_bit(1'b1, 4);
        end
    endtask

    // Monitor: compares every strobe against the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (prev_done) check_output("strobe_width", {31'b0, rx_done_tick}, 32'd0);
            if (rx_done_tick) begin
                strobe_ticks.push_back(tick_count);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_strobe: got strobe with dout=%0h, expected none", dout);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_output("dout", {24'b0, dout}, {24'b0, mon_e.data});
                    check_output("frame_err", {31'b0, frame_err}, {31'b0, mon_e.ferr});
`ifdef UART_RX_PARITY_EN
                    check_output("parity_err", {31'b0, parity_err}, {31'b0, mon_e.perr});
`endif
                end
            end
            prev_done = rx_done_tick;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check_output("reset_dout", {24'b0, dout}, 32'h0);
        check_output("reset_done", {31'b0, rx_done_tick}, 32'h0);
        check_output("reset_ferr", {31'b0, frame_err}, 32'h0);
`ifdef UART_RX_PARITY_EN
        check_output("reset_perr", {31'b0, parity_err}, 32'h0);
`endif
        reset = 1'b0;
        wait_ticks(4);

        $display("[TB] single frame 0x55");
        apply_stimulus(8'h55, 1'b1, 1'b1);
        put_bit(1'b1, 16);

        $display("[TB] back-to-back 0xA3, 0x0F");
        n0 = strobe_ticks.size();
        apply_stimulus(8'hA3, 1'b1, 1'b1);
        apply_stimulus(8'h0F, 1'b1, 1'b1);
        put_bit(1'b1, 16);
        check_output("b2b_count", strobe_ticks.size() - n0, 32'd2);
        if (strobe_ticks.size() >= n0 + 2)
            check_output("b2b_gap", strobe_ticks[n0+1] - strobe_ticks[n0], FRAME_TICKS);

        $display("[TB] start-bit glitch");
        put_bit(1'b0, 4);
        put_bit(1'b1, 32);
        check_output("glitch_dout", {24'b0, dout}, 32'h0F);

        $display("[TB] bad stop bit, then good frame");
        apply_stimulus(8'hFF, 1'b0, 1'b1);
        put_bit(1'b1, 24);
        check_output("ferr_held", {31'b0, frame_err}, 32'h1);
        apply_stimulus(8'h5A, 1'b1, 1'b1);
        put_bit(1'b1, 16);

        $display("[TB] reset during bit 4 of 0x3C");
        put_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) put_bit(n0 >= 0 ? 1'(8'h3C >> i) : 1'b0, 16);
        put_bit(1'b1, 8);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_output("midreset_dout", {24'b0, dout}, 32'h0);
        check_output("midreset_done", {31'b0, rx_done_tick}, 32'h0);
        put_bit(1'b1, 32);
        apply_stimulus(8'h3C, 1'b1, 1'b1);
        put_bit(1'b1, 16);

`ifdef UART_RX_PARITY_EN
        $display("[TB] parity frames 0x07");
        apply_stimulus(8'h07, 1'b1, 1'b1);
        put_bit(1'b1, 16);
        apply_stimulus(8'h07, 1'b1, 1'b0);
        put_bit(1'b1, 16);
`endif

        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        check_output("pending_frames", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
